titan_imem_port: RTL and testbench

//  Responder side of the fetch interface: takes the fetch PC and request from the IF stage and

---
 rtl/titan_imem_pkg.sv | 28 ++
 rtl/titan_imem_timeout.sv | 32 +++
 rtl/titan_imem_port.sv | 152 +++++++++++++++
 tb/tb_titan_imem_port.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/titan_imem_pkg.sv
// Shared types and constants for the instruction-memory fetch port.
package titan_imem_pkg;

    typedef enum logic [1:0] {
        ImemIdle  = 2'd0,
        ImemBusy  = 2'd1,
        ImemDone  = 2'd2,
        ImemDrain = 2'd3
    } imem_state_e;

    // addi x0,x0,0
    localparam logic [31:0] TitanNopInst = 32'h0000_0013;
    localparam logic [3:0]  WbSelAll     = 4'hF;

    // Region test in 33 bits so BASE+SIZE can reach 2^32 without wrapping.
    function automatic logic in_region(input logic [31:0] addr,
                                       input logic [31:0] base,
                                       input logic [31:0] size);
        logic [32:0] a;
        logic [32:0] lo;
        logic [32:0] hi;
        a  = {1'b0, addr};
        lo = {1'b0, base};
        hi = lo + {1'b0, size};
        return (a >= lo) && (a < hi);
    endfunction

endpackage

// File: rtl/titan_imem_timeout.sv
// Saturating bus-wait counter; expired once TIMEOUT_CYCLES-1 cycles have been counted.
module titan_imem_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic enable_i,
    output logic expired_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES) + 1;

    logic [CntW-1:0] count_q;

    // Count while enabled, stopping at all-ones instead of wrapping.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else if (clear_i) begin
            count_q <= '0;
        end else if (enable_i && (count_q != {CntW{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    // Compare against the last allowed wait cycle.
    always_comb begin
        expired_o = (count_q >= CntW'(TIMEOUT_CYCLES - 1));
    end

endmodule

// File: rtl/titan_imem_port.sv
// Fetch-side responder: screens the PC, runs a Wishbone-classic read and returns the word.
module titan_imem_port
    import titan_imem_pkg::*;
#(
    parameter logic [31:0] IMEM_BASE      = 32'h0000_0000,
    parameter logic [31:0] IMEM_SIZE      = 32'h0001_0000,
    parameter int unsigned TIMEOUT_CYCLES = 16,
    parameter logic [31:0] NOP_INST       = TitanNopInst
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] if_pc_i,
    input  logic        if_req_i,
    input  logic        if_flush_i,
    output logic [31:0] if_instruction_o,
    output logic        if_inst_access_fault_o,
    output logic        if_stall_o,
    output logic [31:0] wb_addr_o,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_err_i
);

    imem_state_e state_q, state_d;
    logic        cyc_q, cyc_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] inst_q, inst_d;
    logic        fault_q, fault_d;
    logic        tmo_clear;
    logic        tmo_enable;
    logic        tmo_expired;
    logic        pc_in_range;

    titan_imem_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (tmo_clear),
        .enable_i  (tmo_enable),
        .expired_o (tmo_expired)
    );

    // Address screen against the executable region.
    always_comb begin
        pc_in_range = in_region(if_pc_i, IMEM_BASE, IMEM_SIZE);
    end

    // State, bus and response registers; reset drops the bus cycle immediately.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ImemIdle;
            cyc_q   <= 1'b0;
            addr_q  <= '0;
            inst_q  <= NOP_INST;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            addr_q  <= addr_d;
            inst_q  <= inst_d;
            fault_q <= fault_d;
        end
    end

    // Next-state and response selection.
    always_comb begin
        state_d    = state_q;
        cyc_d      = cyc_q;
        addr_d     = addr_q;
        inst_d     = inst_q;
        fault_d    = fault_q;
        tmo_clear  = 1'b0;
        tmo_enable = 1'b0;
        unique case (state_q)
            ImemIdle: begin
                if (if_req_i && !if_flush_i) begin
                    if (pc_in_range) begin
                        addr_d    = {if_pc_i[31:2], 2'b00};
                        cyc_d     = 1'b1;
                        tmo_clear = 1'b1;
                        state_d   = ImemBusy;
                    end else begin
                        fault_d = 1'b1;
                        inst_d  = NOP_INST;
                        state_d = ImemDone;
                    end
                end
            end
            ImemBusy: begin
                tmo_enable = 1'b1;
                if (if_flush_i) begin
                    // A response landing with the flush is simply dropped.
                    if (wb_ack_i || wb_err_i || tmo_expired) begin
                        cyc_d   = 1'b0;
                        state_d = ImemIdle;
                    end else begin
                        state_d = ImemDrain;
                    end
                end else if (wb_err_i || tmo_expired) begin
                    cyc_d   = 1'b0;
                    fault_d = 1'b1;
                    inst_d  = NOP_INST;
                    state_d = ImemDone;
                end else if (wb_ack_i) begin
                    cyc_d   = 1'b0;
                    fault_d = 1'b0;
                    inst_d  = wb_dat_i;
                    state_d = ImemDone;
                end
            end
            ImemDrain: begin
                // Counter keeps running so BUSY+DRAIN together stay bounded.
                tmo_enable = 1'b1;
                if (wb_ack_i || wb_err_i || tmo_expired) begin
                    cyc_d   = 1'b0;
                    state_d = ImemIdle;
                end
            end
            ImemDone: begin
                if (if_flush_i) begin
                    inst_d  = NOP_INST;
                    fault_d = 1'b0;
                    state_d = ImemIdle;
                end else if (if_req_i) begin
                    state_d = ImemIdle;
                end
            end
            default: begin
                cyc_d   = 1'b0;
                state_d = ImemIdle;
            end
        endcase
    end

    // Registered bus outputs and the combinational stall.
    always_comb begin
        wb_cyc_o               = cyc_q;
        wb_stb_o               = cyc_q;
        wb_addr_o              = addr_q;
        wb_sel_o               = WbSelAll;
        wb_we_o                = 1'b0;
        if_instruction_o       = inst_q;
        if_inst_access_fault_o = fault_q;
        if_stall_o             = if_req_i && (state_q != ImemDone);
    end

endmodule

// File: tb/tb_titan_imem_port.sv
// Directed and randomized fetch bench for titan_imem_port with a transaction-level model.
module tb_titan_imem_port;

    localparam int unsigned TMO = 16;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] if_pc;
    logic        if_req;
    logic        if_flush;
    logic [31:0] if_inst;
    logic        if_fault;
    logic        if_stall;
    logic [31:0] wb_addr;
    logic        wb_cyc;
    logic        wb_stb;
    logic [3:0]  wb_sel;
    logic        wb_we;
    logic [31:0] wb_dat;
    logic        wb_ack;
    logic        wb_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    titan_imem_port #(
        .IMEM_BASE      (32'h0000_0000),
        .IMEM_SIZE      (32'h0001_0000),
        .TIMEOUT_CYCLES (TMO),
        .NOP_INST       (NOP)
    ) dut (
        .clk_i                  (clk),
        .rst_i                  (rst),
        .if_pc_i                (if_pc),
        .if_req_i               (if_req),
        .if_flush_i             (if_flush),
        .if_instruction_o       (if_inst),
        .if_inst_access_fault_o (if_fault),
        .if_stall_o             (if_stall),
        .wb_addr_o              (wb_addr),
        .wb_cyc_o               (wb_cyc),
        .wb_stb_o               (wb_stb),
        .wb_sel_o               (wb_sel),
        .wb_we_o                (wb_we),
        .wb_dat_i               (wb_dat),
        .wb_ack_i               (wb_ack),
        .wb_err_i               (wb_err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected outcome of one fetch. kind: 0 ack, 1 err+ack, 2 silent slave, 3 err only.
    function automatic void model(input logic [31:0] pc, input int kind, input int lat,
                                  input logic [31:0] dat, output logic [31:0] e_inst,
                                  output logic e_fault, output int e_stalls, output logic e_bus);
        if (pc >= 32'h0001_0000) begin
            e_inst = NOP; e_fault = 1'b1; e_stalls = 1; e_bus = 1'b0;
        end else if (kind == 2) begin
            e_inst = NOP; e_fault = 1'b1; e_stalls = 1 + TMO; e_bus = 1'b1;
        end else if (kind == 0) begin
            e_inst = dat; e_fault = 1'b0; e_stalls = 2 + lat; e_bus = 1'b1;
        end else begin
            e_inst = NOP; e_fault = 1'b1; e_stalls = 2 + lat; e_bus = 1'b1;
        end
    endfunction

    // Starts at posedge+1 in IDLE; ends at posedge+1 (consume) or posedge+2 in DONE (no consume).
    task automatic do_fetch(input string tag, input logic [31:0] pc, input int kind, input int lat,
                            input logic [31:0] dat, input bit consume);
        logic [31:0] e_inst;
        logic        e_fault;
        int          e_st;
        logic        e_bus;
        int          n;
        int          bc;
        logic        seen;
        bit          done;
        model(pc, kind, lat, dat, e_inst, e_fault, e_st, e_bus);
        n = 0; bc = 0; seen = 1'b0; done = 1'b0;
        if_pc = pc; if_req = 1'b1; if_flush = 1'b0;
        wb_ack = 1'b0; wb_err = 1'b0;
        while (!done) begin
            #1;
            if (!if_stall) begin
                done = 1'b1;
            end else begin
                n++;
                if (wb_cyc) begin
                    bc++;
                    if (!seen) begin
                        seen = 1'b1;
                        check({tag, " addr"}, wb_addr, {pc[31:2], 2'b00});
                    end
                end
                wb_ack = wb_cyc && (bc == lat + 1) && (kind == 0 || kind == 1);
                wb_err = wb_cyc && (bc == lat + 1) && (kind == 1 || kind == 3);
                wb_dat = (wb_cyc && (bc == lat + 1)) ? dat : $urandom;
                if (n > 60) done = 1'b1;
                step();
                wb_ack = 1'b0;
                wb_err = 1'b0;
            end
        end
        check({tag, " stall_cycles"}, n, e_st);
        check({tag, " inst"}, if_inst, e_inst);
        check({tag, " fault"}, if_fault, e_fault);
        check({tag, " cyc_dropped"}, wb_cyc, 1'b0);
        check({tag, " bus_used"}, seen, e_bus);
        if (consume) begin
            step();
            if_req = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=running expected=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] pc;
        rst = 1'b1; if_req = 1'b1; if_pc = 32'h0; if_flush = 1'b0;
        wb_dat = 32'h0; wb_ack = 1'b0; wb_err = 1'b0;
        #12;
        // Reset state
        check("rst stall_req", if_stall, 1'b1);
        check("rst inst", if_inst, NOP);
        check("rst fault", if_fault, 1'b0);
        check("rst cyc", wb_cyc, 1'b0);
        check("rst addr", wb_addr, 32'h0);
        check("rst sel", wb_sel, 4'hF);
        check("rst we", wb_we, 1'b0);
        if_req = 1'b0;
        #1;
        check("rst stall_noreq", if_stall, 1'b0);
        step();
        rst = 1'b0;
        step();

        // Normal fetch, then range fault, error and timeout
        do_fetch("t2", 32'h0000_0100, 0, 0, 32'h0050_0093, 1'b1);
        do_fetch("t3", 32'h0002_0000, 0, 0, 32'h1111_1111, 1'b1);
        do_fetch("t4err", 32'h0000_0104, 1, 1, 32'h2222_2222, 1'b1);
        do_fetch("t4tmo", 32'h0000_0108, 2, 0, 32'h3333_3333, 1'b1);
        do_fetch("edge_last", 32'h0000_FFFF, 0, 0, 32'h4444_4444, 1'b1);
        do_fetch("edge_end", 32'h0001_0000, 0, 0, 32'h5555_5555, 1'b1);
        do_fetch("edge_top", 32'hFFFF_FFFC, 0, 0, 32'h6666_6666, 1'b1);
        do_fetch("t2b", 32'h0000_0180, 0, 2, 32'h00A0_0113, 1'b1);

        // Reset while a bus cycle is open
        if_pc = 32'h0000_0040; if_req = 1'b1;
        step();
        #1;
        check("t1 pre_cyc", wb_cyc, 1'b1);
        rst = 1'b1;
        #1;
        check("t1 cyc", wb_cyc, 1'b0);
        check("t1 stb", wb_stb, 1'b0);
        check("t1 inst", if_inst, NOP);
        check("t1 fault", if_fault, 1'b0);
        check("t1 addr", wb_addr, 32'h0);
        check("t1 stall_idle", if_stall, 1'b1);
        if_req = 1'b0;
        step();
        rst = 1'b0;
        step();

        // Stale ack in IDLE must not start anything
        wb_ack = 1'b1; wb_dat = 32'hBAD0_BAD0;
        step();
        wb_ack = 1'b0;
        #1;
        check("stale cyc", wb_cyc, 1'b0);
        check("stale inst", if_inst, NOP);
        if_req = 1'b1;
        #1;
        check("stale stall_idle", if_stall, 1'b1);
        if_req = 1'b0;
        step();

        // Flush in BUSY, late ack drained and discarded
        if_pc = 32'h0000_0300; if_req = 1'b1;
        step();
        if_flush = 1'b1;
        step();
        if_flush = 1'b0; if_req = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            #1;
            check($sformatf("t5 hold%0d", i), wb_cyc, 1'b1);
            if (i == 3) begin
                wb_ack = 1'b1;
                wb_dat = 32'hDEAD_BEEF;
            end
            step();
            wb_ack = 1'b0;
        end
        #1;
        check("t5 drop", wb_cyc, 1'b0);
        step();
        do_fetch("t5new", 32'h0000_0200, 0, 0, 32'h0020_0293, 1'b1);

        // Flush while the response is held in DONE
        do_fetch("t7", 32'h0000_0010, 0, 2, 32'h1234_5678, 1'b0);
        if_flush = 1'b1;
        step();
        if_flush = 1'b0; if_req = 1'b0;
        #1;
        check("t7 inst", if_inst, NOP);
        check("t7 fault", if_fault, 1'b0);
        check("t7 cyc", wb_cyc, 1'b0);
        step();

        // Back-pressure: hold DONE for 5 cycles, then consume
        do_fetch("t6", 32'h0000_0020, 0, 1, 32'hABCD_0001, 1'b0);
        if_req = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            step();
            #1;
            check($sformatf("t6 hold%0d", i), if_inst, 32'hABCD_0001);
            check($sformatf("t6 nobus%0d", i), wb_cyc, 1'b0);
        end
        if_req = 1'b1;
        step();
        #1;
        check("t6 idle", if_stall, 1'b1);
        if_req = 1'b0;
        step();

        // Randomized fetches against the model
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 7) == 0) pc = 32'h0001_0000 + $urandom_range(0, 1000);
            else pc = $urandom_range(0, 32'h0000_FFFF);
            do_fetch($sformatf("rnd%0d", i), pc, $urandom_range(0, 3), $urandom_range(0, 3),
                     $urandom, 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
